// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding, line geometry
// and the address field positions used to build burst beat addresses.
package mem_arbiter_pkg;

  localparam int WORD_NUM          = 4;
  localparam int WORD_OFFSET_WIDTH = 2;

  // Address fields of a byte address inside a 4-word line
  localparam int WOFF_HI = 3;  // word offset [3:2]
  localparam int WOFF_LO = 2;
  localparam int BOFF_HI = 1;  // byte offset [1:0]
  localparam int BOFF_LO = 0;
  localparam int LINE_LO = 4;  // line base [ADR_WIDTH-1:4]

  localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = WORD_OFFSET_WIDTH'(WORD_NUM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BURST   = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the port
// that did not own the resource last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       vld,
  output logic       win
);

  // Winner select; win is only meaningful while vld is high
  always_comb begin
    vld = |req;
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_owner;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the external memory port between the I-cache (port 0) and D-cache
// (port 1). Each grant runs one critical-word-first 4-beat burst; memory acks
// and data are steered combinationally back to the owning port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADR_WIDTH  = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_c0,
  input  logic                         req_c1,
  input  logic [ADR_WIDTH-1:0]         adr_c0,
  input  logic [ADR_WIDTH-1:0]         adr_c1,
  output logic                         ack_a2c0,
  output logic                         ack_a2c1,
  output logic [WORD_WIDTH-1:0]        dat_a2c0,
  output logic [WORD_WIDTH-1:0]        dat_a2c1,
  output logic [WORD_OFFSET_WIDTH-1:0] word_a2c0,
  output logic [WORD_OFFSET_WIDTH-1:0] word_a2c1,
  output logic [1:0]                   gnt,
  output logic                         req_a2mem,
  output logic [ADR_WIDTH-1:0]         adr_a2mem,
  input  logic                         ack_mem2a,
  input  logic [WORD_WIDTH-1:0]        dat_mem2a
);

  localparam int NUM_PORTS = 2;

  arb_state_t                      state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            last_q, last_d;
  logic [ADR_WIDTH-1:LINE_LO]      base_q, base_d;
  logic [WORD_OFFSET_WIDTH-1:0]    cnt_q, cnt_d;
  logic [WORD_OFFSET_WIDTH-1:0]    beats_q, beats_d;

  logic                            pick_vld, pick_win;
  logic [ADR_WIDTH-1:0]            sel_adr;

  logic [NUM_PORTS-1:0]                        rtn_ack;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]        rtn_dat;
  logic [NUM_PORTS-1:0][WORD_OFFSET_WIDTH-1:0] rtn_word;

  // Beats are word-addressed, so requester byte offsets are never used
  logic unused_boff;
  assign unused_boff = ^{adr_c0[BOFF_HI:BOFF_LO], adr_c1[BOFF_HI:BOFF_LO]};

  rr_pick2 u_pick (
    .req        ({req_c1, req_c0}),
    .last_owner (last_q),
    .vld        (pick_vld),
    .win        (pick_win)
  );

  assign sel_adr = pick_win ? adr_c1 : adr_c0;

  // State and burst context; reset discards any in-flight burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      base_q  <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
    end
  end

  // Next-state, burst counters and memory-side outputs
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    gnt       = '0;
    req_a2mem = 1'b0;
    adr_a2mem = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_win;
          base_d  = sel_adr[ADR_WIDTH-1:LINE_LO];
          cnt_d   = sel_adr[WOFF_HI:WOFF_LO];
          beats_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        req_a2mem      = 1'b1;
        adr_a2mem      = {base_q, cnt_q, 2'b00};
        gnt[owner_q]   = 1'b1;
        if (ack_mem2a) begin
          cnt_d   = cnt_q + 1'b1;
          beats_d = beats_q + 1'b1;
          if (beats_q == LAST_BEAT) begin
            state_d = RELEASE;
            last_d  = owner_q;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-port return path: only the owner sees acks, data is zero otherwise
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rtn
    assign rtn_ack[p]  = (state_q == BURST) && ack_mem2a && (owner_q == 1'(p));
    assign rtn_dat[p]  = rtn_ack[p] ? dat_mem2a : '0;
    assign rtn_word[p] = rtn_ack[p] ? cnt_q : '0;
  end

  assign ack_a2c0  = rtn_ack[0];
  assign ack_a2c1  = rtn_ack[1];
  assign dat_a2c0  = rtn_dat[0];
  assign dat_a2c1  = rtn_dat[1];
  assign word_a2c0 = rtn_word[0];
  assign word_a2c1 = rtn_word[1];

endmodule
